// File: rtl/generador_vc.sv
// generador_vc: per-VC traffic source for the QoS ingress port.
// Holds a word budget per virtual channel and emits one {vc_id, data_word}
// per cycle, round-robin among VCs that still have words and are not paused.
// Optional feature macro: GENERADOR_REINTENTO_EN. When it is defined, a word
// rejected through error_full is re-queued and resent after continuar.
// Without it, error_full is ignored and rejected words are lost.
module generador_vc #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int BUF_WIDTH      = 3,
    parameter int MAX_WORDS      = 15,
    localparam int CNT_W         = $clog2(MAX_WORDS + 1),
    localparam int VC_W          = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enb,
    input  logic                              iniciar,
    input  logic [QUEUE_QUANTITY*CNT_W-1:0]   cantidad,
    input  logic [QUEUE_QUANTITY-1:0]         pausa,
    input  logic [QUEUE_QUANTITY-1:0]         continuar,
    input  logic [QUEUE_QUANTITY-1:0]         error_full,
    output logic                              push,
    output logic [VC_W-1:0]                   vc_id,
    output logic [BUF_WIDTH:0]                data_word,
    output logic [QUEUE_QUANTITY-1:0]         pausado,
    output logic                              idle,
    output logic                              fin
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENVIO  = 2'd1;
    localparam logic [1:0] ST_ESPERA = 2'd2;
    localparam logic [1:0] ST_FIN    = 2'd3;

    localparam logic [VC_W-1:0]    ULTIMO_INI = VC_W'(QUEUE_QUANTITY - 1);
    localparam logic [CNT_W-1:0]   CNT_CERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_UNO    = CNT_W'(1);
    localparam logic [BUF_WIDTH:0] SEQ_CERO   = {(BUF_WIDTH+1){1'b0}};
    localparam logic [BUF_WIDTH:0] SEQ_UNO    = (BUF_WIDTH+1)'(1);

    // Registered state
    logic [1:0]                state_r;
    logic [CNT_W-1:0]          restante_r  [QUEUE_QUANTITY];
    logic [BUF_WIDTH:0]        secuencia_r [QUEUE_QUANTITY];
    logic [VC_W-1:0]           ultimo_r;
    logic [QUEUE_QUANTITY-1:0] pausado_r;
    logic                      push_r;
    logic [VC_W-1:0]           vc_id_r;
    logic [BUF_WIDTH:0]        data_word_r;
    logic                      idle_r;
    logic                      fin_r;

    // Combinational helpers
    logic [QUEUE_QUANTITY-1:0] rechazo_s;
    logic                      hay_rechazo_s;
    logic [QUEUE_QUANTITY-1:0] pausado_next_s;
    logic [QUEUE_QUANTITY-1:0] elegible_s;
    logic [VC_W-1:0]           grant_s;
    logic                      grant_found_s;
    logic                      grant_valid_s;
    logic [CNT_W-1:0]          restante_next_s  [QUEUE_QUANTITY];
    logic [BUF_WIDTH:0]        secuencia_next_s [QUEUE_QUANTITY];
    logic                      quedan_s;
    logic                      cantidad_cero_s;

`ifdef GENERADOR_REINTENTO_EN
    assign rechazo_s = error_full;
`else
    logic unused_error_full_s;
    assign rechazo_s           = {QUEUE_QUANTITY{1'b0}};
    assign unused_error_full_s = ^error_full;
`endif

    assign hay_rechazo_s   = |rechazo_s;
    assign cantidad_cero_s = (cantidad == {(QUEUE_QUANTITY*CNT_W){1'b0}});

    // Pause tracking (pausa beats continuar; a rejected word pauses its VC) and eligibility
    always_comb begin
        pausado_next_s = pausa | (pausado_r & ~continuar) | rechazo_s;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            elegible_s[i] = (restante_r[i] != CNT_CERO) && !pausado_next_s[i];
        end
    end

    // Round-robin search starting just after the last granted VC
    always_comb begin
        grant_s       = {VC_W{1'b0}};
        grant_found_s = 1'b0;
        for (int k = 1; k <= QUEUE_QUANTITY; k++) begin
            int idx;
            idx = (int'(ultimo_r) + k) % QUEUE_QUANTITY;
            if (!grant_found_s && elegible_s[idx]) begin
                grant_s       = VC_W'(idx);
                grant_found_s = 1'b1;
            end else begin
                grant_s       = grant_s;
                grant_found_s = grant_found_s;
            end
        end
        grant_valid_s = grant_found_s && ((state_r == ST_ENVIO) || (state_r == ST_ESPERA));
    end

    // Next per-VC budget and sequence number: a grant consumes a word, a rejection gives it back
    always_comb begin
        quedan_s = 1'b0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (grant_valid_s && (grant_s == VC_W'(i))) begin
                restante_next_s[i]  = restante_r[i] - CNT_UNO;
                secuencia_next_s[i] = secuencia_r[i] + SEQ_UNO;
            end else if (rechazo_s[i]) begin
                restante_next_s[i]  = restante_r[i] + CNT_UNO;
                secuencia_next_s[i] = secuencia_r[i] - SEQ_UNO;
            end else begin
                restante_next_s[i]  = restante_r[i];
                secuencia_next_s[i] = secuencia_r[i];
            end
            quedan_s = quedan_s | (restante_next_s[i] != CNT_CERO);
        end
    end

    // Per-VC pause status register; frozen while enb is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            pausado_r <= {QUEUE_QUANTITY{1'b0}};
        end else if (enb) begin
            pausado_r <= pausado_next_s;
        end
    end

    // Run control FSM with per-VC counters and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            ultimo_r <= ULTIMO_INI;
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                restante_r[i]  <= CNT_CERO;
                secuencia_r[i] <= SEQ_CERO;
            end
        end else if (enb) begin
            case (state_r)
                ST_IDLE: begin
                    if (iniciar) begin
                        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                            restante_r[i]  <= cantidad[i*CNT_W +: CNT_W];
                            secuencia_r[i] <= SEQ_CERO;
                        end
                        ultimo_r <= ULTIMO_INI;
                        state_r  <= cantidad_cero_s ? ST_FIN : ST_ENVIO;
                    end else begin
                        // A late rejection after the run finished reopens it
                        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                            restante_r[i]  <= restante_next_s[i];
                            secuencia_r[i] <= secuencia_next_s[i];
                        end
                        if (hay_rechazo_s) begin
                            state_r <= ST_ESPERA;
                        end
                    end
                end
                ST_ENVIO, ST_ESPERA: begin
                    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                        restante_r[i]  <= restante_next_s[i];
                        secuencia_r[i] <= secuencia_next_s[i];
                    end
                    if (grant_valid_s) begin
                        ultimo_r <= grant_s;
                        state_r  <= quedan_s ? ST_ENVIO : ST_FIN;
                    end else begin
                        state_r  <= quedan_s ? ST_ESPERA : ST_FIN;
                    end
                end
                ST_FIN: begin
                    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                        restante_r[i]  <= restante_next_s[i];
                        secuencia_r[i] <= secuencia_next_s[i];
                    end
                    state_r <= hay_rechazo_s ? ST_ESPERA : ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered outputs: push/vc_id/data_word of the grant, idle and fin from the current state
    always_ff @(posedge clk) begin
        if (!rst) begin
            push_r      <= 1'b0;
            vc_id_r     <= {VC_W{1'b0}};
            data_word_r <= SEQ_CERO;
            idle_r      <= 1'b1;
            fin_r       <= 1'b0;
        end else if (enb) begin
            push_r <= grant_valid_s;
            if (grant_valid_s) begin
                vc_id_r     <= grant_s;
                data_word_r <= secuencia_r[grant_s];
            end
            idle_r <= (state_r == ST_IDLE);
            fin_r  <= (state_r == ST_FIN);
        end else begin
            push_r <= 1'b0;
            fin_r  <= 1'b0;
        end
    end

    assign push      = push_r;
    assign vc_id     = vc_id_r;
    assign data_word = data_word_r;
    assign pausado   = pausado_r;
    assign idle      = idle_r;
    assign fin       = fin_r;

endmodule

// File: doc/generador_vc.md
# generador_vc

Traffic source feeding the QoS ingress port. Holds a per-virtual-channel word budget, emits one `{vc_id, data_word}` per cycle with a push strobe, and round-robins among VCs that still have words and are not paused. It obeys the QoS per-VC `pausa`/`continuar` flow control and can optionally retransmit words rejected by `error_full`.

## Interface
- `QUEUE_QUANTITY`, 4: number of VCs.
- `BUF_WIDTH`, 3: data word is `BUF_WIDTH+1` bits.
- `MAX_WORDS`, 15: maximum words per VC per run; `CNT_W = $clog2(MAX_WORDS+1)`.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `enb`  in  1: global enable; low freezes all state and forces `push`=0.
- `iniciar`  in  1: start a run; sampled only in IDLE.
- `cantidad`  in  `QUEUE_QUANTITY*CNT_W`: words to send per VC; VC i at `[i*CNT_W +: CNT_W]`; latched on start.
- `pausa`  in  `QUEUE_QUANTITY`: per-VC pause from QoS.
- `continuar`  in  `QUEUE_QUANTITY`: per-VC resume from QoS.
- `error_full`  in  `QUEUE_QUANTITY`: per-VC rejected-write flag from QoS.
- `push`  out  1: `vc_id`/`data_word` valid this cycle.
- `vc_id`  out  `$clog2(QUEUE_QUANTITY)`: target VC.
- `data_word`  out  `BUF_WIDTH+1`: payload, per-VC sequence number.
- `pausado`  out  `QUEUE_QUANTITY`: registered pause status per VC.
- `idle`  out  1: high in IDLE.
- `fin`  out  1: one-cycle pulse when a run completes.

## Operation
- State per VC: `restante[i]` (CNT_W bits), `secuencia[i]` (BUF_WIDTH+1 bits, wraps mod 2^(BUF_WIDTH+1)), `pausado[i]`. Shared: round-robin pointer `ultimo`.
- Pause tracking: `pausado_next[i] = pausa[i] | (pausado[i] & ~continuar[i])`; `pausa` wins over `continuar` in the same cycle.
- Eligible VC i: `restante[i] != 0 && !pausado_next[i]`.
- Arbitration: first eligible VC searching `ultimo+1, ultimo+2, …` with wrap to 0; `ultimo` updates to the granted VC.
- States:
  - IDLE: `idle`=1. When `iniciar & enb`: latch `cantidad`, clear `secuencia`, set `ultimo = QUEUE_QUANTITY-1`. Go to FIN if all counts are 0, else ENVIO.
  - ENVIO: if a VC is eligible, register `push`=1, `vc_id`=grant, `data_word`=`secuencia[grant]`; then decrement `restante`, increment `secuencia`. If none is eligible but some `restante` is nonzero, go to ESPERA with `push`=0. When the last word is granted, go to FIN next.
  - ESPERA: `push`=0. Return to ENVIO at the first edge where any VC is eligible; the grant is made at that same edge.
  - FIN: `fin`=1 for one cycle, `push`=0, then IDLE.
- `iniciar` outside IDLE is ignored. `pausado` keeps updating in every state, including IDLE.
- `enb`=0: no state or counter changes, and `push` is registered 0.

## Timing
- All outputs are registered.
- Reset values: `push`=0, `vc_id`=0, `data_word`=0, `pausado`=0, `idle`=1, `fin`=0. All `restante`/`secuencia` are 0, `ultimo`=QUEUE_QUANTITY-1, state IDLE.
- Reset mid-run: abort immediately, with no further pushes.
- `iniciar` sampled at edge k: first `push` is visible after edge k+1. Throughput is 1 word/cycle while any VC is eligible.
- Flow-control response is zero-latency. If `pausa[i]` is high at edge k, no word for VC i is launched at edge k. If `continuar[i]` is high at edge k (with `pausa[i]` low), VC i may be granted at edge k.
- Last word launched at edge k: `fin` is high after edge k+1; `idle` is high after edge k+2.

## Configuration
- `GENERADOR_REINTENTO_EN` defined: `error_full[i]` high at edge k means the most recent word sent on VC i was rejected. At edge k: `restante[i]` += 1, `secuencia[i]` -= 1, `pausado[i]` set. The word is resent after `continuar[i]`. If this happens in FIN or IDLE, the state returns to ESPERA.
- Not defined: `error_full` is ignored and the word is lost.

## Test plan
- Reset: `rst`=0 for 2 cycles during ENVIO -> `push`=0, `idle`=1, `pausado`=0, and no pushes until a new `iniciar`.
- `cantidad`={1,1,1,1}, no pausa -> pushes to VC 0,1,2,3 on consecutive cycles, each with data 0; `fin` pulses one cycle later, then `idle`=1.
- `cantidad`: VC0=3, others 0 -> VC0 data 0,1,2 back-to-back, then `fin`.
- All `cantidad`=2, `pausa[1]` high at start, `continuar[1]` 6 cycles later -> order 0,2,3,0,2,3, then ESPERA with `push`=0, then VC1 data 0,1.
- `pausa`=4'b1111 mid-run and `pausa`/`continuar[2]` high in the same cycle -> `push`=0 and VC2 stays paused; `continuar[3]` alone resumes VC3 at that edge.
- With `GENERADOR_REINTENTO_EN`: `error_full[2]` after VC2 word 0 -> VC2 paused; after `continuar[2]`, VC2 word 0 is resent, followed by word 1.
